// File: rtl/aq_axis_reduce_pow2.sv
// aq_axis_reduce_pow2
// Multi-channel AXI-Stream video downscaler. Horizontally picks the first
// pixel of, or box-averages, each group of 2^SHIFT_X pixels, and keeps one
// line out of every 2^SHIFT_Y. Frame and line boundaries travel in-band on
// TUSER (start of frame) and TLAST (end of line). A single output register
// gives one cycle of latency and full TREADY backpressure.
module aq_axis_reduce_pow2 #(
   parameter int NCH       = 3,
   parameter int CW        = 8,
   parameter int MAX_SHIFT = 4
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic                CFG_MODE,
   input  logic [2:0]          CFG_SHIFT_X,
   input  logic [2:0]          CFG_SHIFT_Y,
   input  logic [NCH*CW-1:0]   S_AXIS_TDATA,
   input  logic                S_AXIS_TUSER,
   input  logic                S_AXIS_TLAST,
   input  logic                S_AXIS_TVALID,
   output logic                S_AXIS_TREADY,
   output logic [NCH*CW-1:0]   M_AXIS_TDATA,
   output logic                M_AXIS_TUSER,
   output logic                M_AXIS_TLAST,
   output logic                M_AXIS_TVALID,
   input  logic                M_AXIS_TREADY,
   output logic [15:0]         STAT_FRAMES,
   output logic                STAT_SOF_ERR
);

   localparam int DW = NCH * CW;
   localparam int AW = CW + MAX_SHIFT;
   localparam int RW = 12;

   typedef enum logic [0:0] {ST_WAIT_SOF = 1'b0, ST_RUN = 1'b1} state_t;

   // Shift requests beyond the accumulator headroom are clamped
   function automatic logic [2:0] clamp_shift(input logic [2:0] v);
      logic [2:0] r;
      if (v > 3'(MAX_SHIFT)) r = 3'(MAX_SHIFT);
      else                   r = v;
      return r;
   endfunction

   // Column index of the last pixel of a group: 2^sh - 1
   function automatic logic [MAX_SHIFT-1:0] group_last(input logic [2:0] sh);
      logic [MAX_SHIFT-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_SHIFT; i++) begin
         if (i < int'(sh)) m[i] = 1'b1;
         else              m[i] = 1'b0;
      end
      return m;
   endfunction

   // A line is kept when its low sh bits of the row counter are all zero
   function automatic logic row_is_kept(input logic [RW-1:0] row, input logic [2:0] sh);
      logic k;
      k = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if ((i < int'(sh)) && row[i]) k = 1'b0;
         else                          k = k;
      end
      return k;
   endfunction

   state_t                 state_r, state_nx_s;
   logic                   mode_r, first_r, line_act_r;
   logic [2:0]             shx_r, shy_r;
   logic [MAX_SHIFT-1:0]   col_r;
   logic [RW-1:0]          row_r;
   logic [AW-1:0]          acc_r    [NCH];
   logic [AW-1:0]          acc_nx_s [NCH];
   logic [DW-1:0]          m_data_r, out_pix_s;
   logic                   m_user_r, m_last_r, m_valid_r;
   logic [15:0]            frames_r;
   logic                   sof_err_r;

   logic                   s_ready_s, accept_s, sof_acc_s, proc_s;
   logic                   eff_mode_s, eff_first_s, group_end_s, row_kept_s, emit_s;
   logic [2:0]             eff_shx_s, eff_shy_s;
   logic [MAX_SHIFT-1:0]   eff_col_s;
   logic [RW-1:0]          eff_row_s;

   assign s_ready_s     = ~m_valid_r | M_AXIS_TREADY;
   assign accept_s      = S_AXIS_TVALID & s_ready_s;
   assign sof_acc_s     = accept_s & S_AXIS_TUSER;

   assign S_AXIS_TREADY = s_ready_s;
   assign M_AXIS_TDATA  = m_data_r;
   assign M_AXIS_TUSER  = m_user_r;
   assign M_AXIS_TLAST  = m_last_r;
   assign M_AXIS_TVALID = m_valid_r;
   assign STAT_FRAMES   = frames_r;
   assign STAT_SOF_ERR  = sof_err_r;

   // State register
   always_ff @(posedge ACLK) begin
      if (ARESET) state_r <= ST_WAIT_SOF;
      else        state_r <= state_nx_s;
   end

   // Next state: leave WAIT_SOF on the first accepted start-of-frame beat
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_WAIT_SOF: begin
            if (sof_acc_s) state_nx_s = ST_RUN;
            else           state_nx_s = ST_WAIT_SOF;
         end
         ST_RUN:  state_nx_s = ST_RUN;
         default: state_nx_s = ST_WAIT_SOF;
      endcase
   end

   // State decode: which accepted beats enter the scaler datapath
   always_comb begin
      proc_s = 1'b0;
      case (state_r)
         ST_WAIT_SOF: proc_s = sof_acc_s;
         ST_RUN:      proc_s = accept_s;
         default:     proc_s = 1'b0;
      endcase
   end

   // Per-beat context (an SOF beat starts a fresh frame) plus group sum and output pixel
   always_comb begin
      logic [CW-1:0] pix_v;
      logic [AW-1:0] base_v;
      logic [AW-1:0] sum_v;
      logic [AW-1:0] avg_v;
      pix_v       = '0;
      base_v      = '0;
      sum_v       = '0;
      avg_v       = '0;
      out_pix_s   = '0;
      eff_mode_s  = sof_acc_s ? CFG_MODE                 : mode_r;
      eff_shx_s   = sof_acc_s ? clamp_shift(CFG_SHIFT_X) : shx_r;
      eff_shy_s   = sof_acc_s ? clamp_shift(CFG_SHIFT_Y) : shy_r;
      eff_col_s   = sof_acc_s ? '0                       : col_r;
      eff_row_s   = sof_acc_s ? '0                       : row_r;
      eff_first_s = sof_acc_s ? 1'b1                     : first_r;
      group_end_s = (eff_col_s == group_last(eff_shx_s)) | S_AXIS_TLAST;
      row_kept_s  = row_is_kept(eff_row_s, eff_shy_s);
      emit_s      = proc_s & group_end_s & row_kept_s;
      for (int c = 0; c < NCH; c++) begin
         pix_v       = S_AXIS_TDATA[c*CW +: CW];
         base_v      = (eff_col_s == '0) ? '0 : acc_r[c];
         sum_v       = base_v + AW'(pix_v);
         avg_v       = sum_v >> eff_shx_s;
         acc_nx_s[c] = eff_mode_s ? sum_v
                                  : ((eff_col_s == '0) ? AW'(pix_v) : acc_r[c]);
         out_pix_s[c*CW +: CW] = eff_mode_s ? avg_v[CW-1:0]
                                            : ((eff_col_s == '0) ? pix_v : acc_r[c][CW-1:0]);
      end
   end

   // Frame settings, group/line position and accumulators advance per processed beat
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         mode_r     <= 1'b0;
         shx_r      <= 3'd0;
         shy_r      <= 3'd0;
         col_r      <= '0;
         row_r      <= '0;
         first_r    <= 1'b0;
         line_act_r <= 1'b0;
         for (int c = 0; c < NCH; c++) acc_r[c] <= '0;
      end else if (proc_s) begin
         mode_r     <= eff_mode_s;
         shx_r      <= eff_shx_s;
         shy_r      <= eff_shy_s;
         col_r      <= group_end_s ? '0 : eff_col_s + MAX_SHIFT'(1);
         row_r      <= S_AXIS_TLAST ? eff_row_s + 12'd1 : eff_row_s;
         first_r    <= emit_s ? 1'b0 : eff_first_s;
         line_act_r <= ~S_AXIS_TLAST;
         for (int c = 0; c < NCH; c++) acc_r[c] <= acc_nx_s[c];
      end
   end

   // One-entry output register: load on emit, clear valid once taken, else hold
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         m_data_r  <= '0;
         m_user_r  <= 1'b0;
         m_last_r  <= 1'b0;
         m_valid_r <= 1'b0;
      end else if (emit_s) begin
         m_data_r  <= out_pix_s;
         m_user_r  <= eff_first_s;
         m_last_r  <= S_AXIS_TLAST;
         m_valid_r <= 1'b1;
      end else if (M_AXIS_TREADY) begin
         m_valid_r <= 1'b0;
      end
   end

   // Frame counter and sticky flag for an SOF that arrives while a line is still open
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         frames_r  <= 16'd0;
         sof_err_r <= 1'b0;
      end else if (sof_acc_s) begin
         frames_r <= frames_r + 16'd1;
         if (line_act_r) sof_err_r <= 1'b1;
      end
   end

endmodule
